// File: rtl/axi_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_pkg
// Shared definitions for the parametrised AXI4-Lite master:
//   state_t      - master FSM state encoding (also exported for debug)
//   RESP_*       - AXI response codes (BRESP / RRESP)
//   PROT_DEFAULT - value driven on AWPROT / ARPROT
// -----------------------------------------------------------------------------
package axi_lite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Unprivileged, secure, data access.
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_watchdog.sv
// -----------------------------------------------------------------------------
// axi_lite_watchdog
// Per-transaction watchdog: a saturating cycle counter with a sticky flag.
//   clk     in  1  clock
//   rst     in  1  asynchronous active-high reset
//   clr     in  1  restart: counter and flag cleared (command accept)
//   run     in  1  count this cycle (transaction in flight)
//   expired out 1  count has reached TIMEOUT; held until the next clr
// TIMEOUT = 0 disables the watchdog (expired stays 0).
// -----------------------------------------------------------------------------
module axi_lite_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;
  logic             r_expired;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_cnt_next = r_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else if (clr) begin
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else if (run && (TIMEOUT > 0) && (r_cnt != LIMIT)) begin
      r_cnt <= w_cnt_next;
      // Flag rises on the same edge the count reaches the limit, so the
      // registered output is high exactly TIMEOUT cycles after accept.
      if (w_cnt_next == LIMIT) begin
        r_expired <= 1'b1;
      end
    end
  end

  assign expired = r_expired;

endmodule

// File: rtl/axi_lite_master_param.sv
// -----------------------------------------------------------------------------
// axi_lite_master_param
// Single-outstanding AXI4-Lite master with a ready/valid command port.
//
// Parameters: ADDR_W (address width), DATA_W (32 or 64), TIMEOUT (watchdog
// limit in cycles, 0 = off). Strobe width is DATA_W/8.
//
// Command side:
//   AXI_CmdValid in, AXI_CmdReady out, AXI_WriteEn/AXI_Addr/AXI_WData/AXI_WStrb in
//   AXI_RData out (last read data), AXI_Resp out (last BRESP/RRESP),
//   AXI_Done out (1-cycle completion pulse), AXI_Timeout out (watchdog flag)
// AXI side: AW, W, B, AR, R channels (M_AXI_*).
// Debug: o_dbg_state exposes the FSM state register.
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// VALID and READY are both 1; a VALID, once raised, is held with stable
// payload until that edge; the command port follows the same rule with
// AXI_CmdValid / AXI_CmdReady.
// -----------------------------------------------------------------------------
module axi_lite_master_param
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  // command port
  input  logic                  AXI_CmdValid,
  output logic                  AXI_CmdReady,
  input  logic                  AXI_WriteEn,
  input  logic [ADDR_W-1:0]     AXI_Addr,
  input  logic [DATA_W-1:0]     AXI_WData,
  input  logic [DATA_W/8-1:0]   AXI_WStrb,
  output logic [DATA_W-1:0]     AXI_RData,
  output logic [1:0]            AXI_Resp,
  output logic                  AXI_Done,
  output logic                  AXI_Timeout,
  // write address channel
  output logic [ADDR_W-1:0]     M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  // write data channel
  output logic [DATA_W-1:0]     M_AXI_WDATA,
  output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  // write response channel
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  // read address channel
  output logic [ADDR_W-1:0]     M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  // read data channel
  input  logic [DATA_W-1:0]     M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,
  // debug
  output logic [2:0]            o_dbg_state
);

  state_t                r_state;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_wstrb;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_arvalid;
  logic                  r_rready;
  logic [DATA_W-1:0]     r_rdata;
  logic [1:0]            r_resp;
  logic                  r_done;

  logic                  w_accept;
  logic                  w_aw_ok;
  logic                  w_w_ok;
  logic                  w_timeout;

  // Ready comes straight from the state register so the command port has
  // no combinational path from any input.
  assign AXI_CmdReady = (r_state == ST_IDLE);
  assign w_accept     = AXI_CmdValid & AXI_CmdReady;

  // A write channel is finished once its VALID is already down or its
  // handshake happens this cycle; this covers AW and W completing in the
  // same cycle as well as in either order.
  assign w_aw_ok = ~r_awvalid | M_AXI_AWREADY;
  assign w_w_ok  = ~r_wvalid  | M_AXI_WREADY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_rdata   <= '0;
      r_resp    <= RESP_OKAY;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (AXI_CmdValid) begin
            r_addr <= AXI_Addr;
            if (AXI_WriteEn) begin
              r_wdata   <= AXI_WData;
              r_wstrb   <= AXI_WStrb;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_WR_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= ST_RD_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          if (M_AXI_AWREADY) begin
            r_awvalid <= 1'b0;
          end
          if (M_AXI_WREADY) begin
            r_wvalid <= 1'b0;
          end
          if (w_aw_ok && w_w_ok) begin
            r_bready <= 1'b1;
            r_state  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (M_AXI_BVALID) begin
            r_resp   <= M_AXI_BRESP;
            r_bready <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        ST_RD_REQ: begin
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (M_AXI_RVALID) begin
            r_rdata  <= M_AXI_RDATA;
            r_resp   <= M_AXI_RRESP;
            r_rready <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // The watchdog only flags; the transaction keeps waiting for the slave.
  axi_lite_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_accept),
    .run     (r_state != ST_IDLE),
    .expired (w_timeout)
  );

  assign AXI_RData     = r_rdata;
  assign AXI_Resp      = r_resp;
  assign AXI_Done      = r_done;
  assign AXI_Timeout   = w_timeout;

  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWPROT  = PROT_DEFAULT;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARPROT  = PROT_DEFAULT;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

  assign o_dbg_state   = r_state;

endmodule
